// File: rtl/gpa_fhdo_pkg.sv
// Shared types for the GPA-FHDO update scheduler and its frame FIFO.
package gpa_fhdo_pkg;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 24;

  typedef logic [NUM_CH*DATA_W-1:0] gpa_frame_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    GUARD = 2'd2,
    WAIT  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/gpa_fhdo_frame_fifo.sv
// Synchronous show-ahead FIFO of gradient frames with a registered fill level.
module gpa_fhdo_frame_fifo #(
  parameter int AW = 4
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          wr_en,
  input  logic [gpa_fhdo_pkg::NUM_CH*gpa_fhdo_pkg::DATA_W-1:0] wr_data,
  output logic                                          full,
  input  logic                                          rd_en,
  output logic [gpa_fhdo_pkg::NUM_CH*gpa_fhdo_pkg::DATA_W-1:0] rd_data,
  output logic [AW:0]                                   level
);
  import gpa_fhdo_pkg::*;

  localparam int DEPTH = 1 << AW;

  gpa_frame_t    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   level_r;
  logic          wr_s;
  logic          rd_s;

  // Full is judged on the registered level only, so a pop never frees a slot early.
  assign full    = level_r[AW];
  assign wr_s    = wr_en && !level_r[AW];
  assign rd_s    = rd_en && (level_r != {(AW+1){1'b0}});
  assign rd_data = mem_r[rd_ptr_r];
  assign level   = level_r;

  // Frame storage
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers and fill level
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {(AW+1){1'b0}};
    end else begin
      if (wr_s) wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      if (rd_s) rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      case ({wr_s, rd_s})
        2'b10:   level_r <= level_r + {{AW{1'b0}}, 1'b1};
        2'b01:   level_r <= level_r - {{AW{1'b0}}, 1'b1};
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/gpa_fhdo_sched.sv
// Update scheduler/arbiter in front of gpa_fhdo_iface: timed stream frames first, host config in the gaps.
// Optional statistics counters are built only with GPA_FHDO_SCHED_STATS_EN defined.
module gpa_fhdo_sched #(
  parameter int DATA_W  = gpa_fhdo_pkg::DATA_W,
  parameter int FIFO_AW = 4,
  parameter int DIV_W   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable_i,
  input  logic [DIV_W-1:0]    interval_i,
  input  logic [4*DATA_W-1:0] strm_data_i,
  input  logic                strm_valid_i,
  output logic                strm_ready_o,
  input  logic [4*DATA_W-1:0] cfg_data_i,
  input  logic                cfg_valid_i,
  output logic                cfg_ready_o,
  output logic [DATA_W-1:0]   datax_o,
  output logic [DATA_W-1:0]   datay_o,
  output logic [DATA_W-1:0]   dataz_o,
  output logic [DATA_W-1:0]   dataz2_o,
  output logic                valid_o,
  input  logic                busy_i,
  output logic [FIFO_AW:0]    fifo_level_o,
  output logic                underrun_o,
  output logic                late_o,
  output logic [15:0]         underrun_cnt_o,
  output logic [15:0]         late_cnt_o
);
  import gpa_fhdo_pkg::*;

  sched_state_t     state_r;
  logic [DIV_W-1:0] cnt_r;
  logic             tick_pending_r;
  logic             tick_s;
  logic             service_s;
  logic             cfg_take_s;
  logic             fifo_empty_s;
  logic             fifo_full_s;
  logic             fifo_rd_s;
  logic             underrun_ev_s;
  logic             late_ev_s;
  gpa_frame_t       fifo_head_s;

  gpa_fhdo_frame_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (strm_valid_i),
    .wr_data (strm_data_i),
    .full    (fifo_full_s),
    .rd_en   (fifo_rd_s),
    .rd_data (fifo_head_s),
    .level   (fifo_level_o)
  );

  // A tick is serviced whether or not a frame is available; an empty FIFO turns it into an underrun.
  assign tick_s        = enable_i && (cnt_r == {DIV_W{1'b0}});
  assign service_s     = (state_r == IDLE) && !busy_i && (tick_pending_r || tick_s);
  assign fifo_empty_s  = (fifo_level_o == {(FIFO_AW+1){1'b0}});
  assign fifo_rd_s     = service_s && !fifo_empty_s;
  assign underrun_ev_s = service_s && fifo_empty_s;
  assign late_ev_s     = tick_s && tick_pending_r;
  assign strm_ready_o  = !fifo_full_s;
  assign cfg_ready_o   = (state_r == IDLE) && !busy_i && !tick_pending_r && !tick_s;
  assign cfg_take_s    = cfg_valid_i && cfg_ready_o;

  // Update-interval down-counter and the single-entry pending-tick flag
  always_ff @(posedge clk) begin
    if (!rst_n || !enable_i) begin
      cnt_r          <= interval_i;
      tick_pending_r <= 1'b0;
    end else begin
      if (tick_s) cnt_r <= interval_i;
      else        cnt_r <= cnt_r - {{(DIV_W-1){1'b0}}, 1'b1};
      if (service_s)   tick_pending_r <= 1'b0;
      else if (tick_s) tick_pending_r <= 1'b1;
      else             tick_pending_r <= tick_pending_r;
    end
  end

  // Issue FSM with registered strobe, data and event pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      valid_o    <= 1'b0;
      datax_o    <= {DATA_W{1'b0}};
      datay_o    <= {DATA_W{1'b0}};
      dataz_o    <= {DATA_W{1'b0}};
      dataz2_o   <= {DATA_W{1'b0}};
      underrun_o <= 1'b0;
      late_o     <= 1'b0;
    end else begin
      valid_o    <= 1'b0;
      underrun_o <= underrun_ev_s;
      late_o     <= late_ev_s;
      case (state_r)
        IDLE: begin
          if (fifo_rd_s) begin
            state_r <= SEND;
            valid_o <= 1'b1;
            {dataz2_o, dataz_o, datay_o, datax_o} <= fifo_head_s;
          end else if (cfg_take_s) begin
            state_r <= SEND;
            valid_o <= 1'b1;
            {dataz2_o, dataz_o, datay_o, datax_o} <= cfg_data_i;
          end else begin
            state_r <= IDLE;
          end
        end
        SEND:  state_r <= GUARD;
        // busy_i is not trusted here: the interface needs a cycle to raise it
        GUARD: state_r <= WAIT;
        WAIT: begin
          if (!busy_i) state_r <= IDLE;
          else         state_r <= WAIT;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

`ifdef GPA_FHDO_SCHED_STATS_EN
  logic [15:0] underrun_cnt_r;
  logic [15:0] late_cnt_r;

  // Saturating event counters, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      underrun_cnt_r <= 16'h0000;
      late_cnt_r     <= 16'h0000;
    end else begin
      if (underrun_ev_s && (underrun_cnt_r != 16'hFFFF)) underrun_cnt_r <= underrun_cnt_r + 16'h0001;
      if (late_ev_s && (late_cnt_r != 16'hFFFF))         late_cnt_r     <= late_cnt_r + 16'h0001;
    end
  end

  assign underrun_cnt_o = underrun_cnt_r;
  assign late_cnt_o     = late_cnt_r;
`else
  assign underrun_cnt_o = 16'h0000;
  assign late_cnt_o     = 16'h0000;
`endif

endmodule

// File: tb/tb_gpa_fhdo_sched.sv
// Self-checking bench for gpa_fhdo_sched: directed scenarios plus randomized traffic against a queue-based model.
module tb_gpa_fhdo_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] interval = 16'd9;
  logic [95:0] strm_data = 96'd0;
  logic        strm_valid = 1'b0;
  logic        strm_ready;
  logic [95:0] cfg_data = 96'd0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [23:0] datax, datay, dataz, dataz2;
  logic        valid_o;
  logic        busy_i = 1'b0;
  logic [4:0]  fifo_level;
  logic        underrun_o, late_o;
  logic [15:0] underrun_cnt, late_cnt;

  always #5 clk = ~clk;

  gpa_fhdo_sched dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable), .interval_i(interval),
    .strm_data_i(strm_data), .strm_valid_i(strm_valid), .strm_ready_o(strm_ready),
    .cfg_data_i(cfg_data), .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
    .datax_o(datax), .datay_o(datay), .dataz_o(dataz), .dataz2_o(dataz2),
    .valid_o(valid_o), .busy_i(busy_i), .fifo_level_o(fifo_level),
    .underrun_o(underrun_o), .late_o(late_o),
    .underrun_cnt_o(underrun_cnt), .late_cnt_o(late_cnt)
  );

  int n_checks = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [95:0] q[$];
  int  cyc = 0;
  int  since_m = 0, period_m = 10, issue_m = 0;
  bit  pend_m = 1'b0, idle_m = 1'b1;
  bit  ev_m = 1'b0, eu_m = 1'b0, el_m = 1'b0;
  logic [95:0] ed_m = 96'd0;
  int  cu_m = 0, cl_m = 0;

  function automatic bit m_tick();
    return enable && (since_m == period_m - 1);
  endfunction

  always @(posedge clk) begin : model
    bit tk, emp, svc, take, wr;
    if (!rst_n) begin
      q.delete();
      since_m = 0; period_m = int'(interval) + 1;
      pend_m = 1'b0; idle_m = 1'b1;
      ev_m = 1'b0; eu_m = 1'b0; el_m = 1'b0; ed_m = 96'd0;
      cu_m = 0; cl_m = 0;
    end else begin
      tk   = m_tick();
      emp  = (q.size() == 0);
      svc  = idle_m && !busy_i && (pend_m || tk);
      take = idle_m && !busy_i && !pend_m && !tk && cfg_valid;
      wr   = strm_valid && (q.size() < 16);
      eu_m = svc && emp;
      el_m = tk && pend_m;
      ev_m = 1'b0;
      if (svc && !emp) begin ed_m = q.pop_front(); ev_m = 1'b1; end
      else if (take)   begin ed_m = cfg_data;      ev_m = 1'b1; end
      if (wr) q.push_back(strm_data);
      // after an issue the scheduler is unavailable for three cycles and until busy has been seen low
      if (ev_m) begin idle_m = 1'b0; issue_m = cyc; end
      else if (!idle_m && cyc >= issue_m + 3 && !busy_i) idle_m = 1'b1;
      if (!enable)  pend_m = 1'b0;
      else if (svc) pend_m = 1'b0;
      else if (tk)  pend_m = 1'b1;
      if (!enable || tk) begin since_m = 0; period_m = int'(interval) + 1; end
      else since_m++;
      if (eu_m && cu_m < 65535) cu_m++;
      if (el_m && cl_m < 65535) cl_m++;
    end
    cyc++;
  end

  // ---------------- interface busy emulation ----------------
  int busy_lo = 1, busy_hi = 3;
  int b_from = 1, b_to = 0;

  always @(posedge clk) begin
    #1;
    if (valid_o === 1'b1) begin
      b_from = cyc + $urandom_range(1, 2);
      b_to   = b_from + $urandom_range(busy_lo, busy_hi) - 1;
    end
    busy_i = (cyc >= b_from) && (cyc <= b_to);
  end

  // ---------------- compare process and event tallies ----------------
  int n_valid = 0, n_under = 0, n_late = 0;

  always @(negedge clk) begin
    if (chk_on) begin
      chk("valid", {95'd0, valid_o}, {95'd0, ev_m});
      chk("data", {dataz2, dataz, datay, datax}, ed_m);
      chk("level", {91'd0, fifo_level}, 96'(q.size()));
      chk("underrun", {95'd0, underrun_o}, {95'd0, eu_m});
      chk("late", {95'd0, late_o}, {95'd0, el_m});
`ifdef GPA_FHDO_SCHED_STATS_EN
      chk("underrun_cnt", {80'd0, underrun_cnt}, 96'(cu_m));
      chk("late_cnt", {80'd0, late_cnt}, 96'(cl_m));
`else
      chk("underrun_cnt", {80'd0, underrun_cnt}, 96'd0);
      chk("late_cnt", {80'd0, late_cnt}, 96'd0);
`endif
      if (rst_n) begin
        chk("strm_ready", {95'd0, strm_ready}, {95'd0, q.size() < 16});
        chk("cfg_ready", {95'd0, cfg_ready},
            {95'd0, idle_m && !busy_i && !pend_m && !m_tick()});
      end
      if (valid_o === 1'b1) n_valid++;
      if (underrun_o === 1'b1) n_under++;
      if (late_o === 1'b1) n_late++;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(input int bound, input string nm);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (valid_o !== 1'b1 && k < bound);
    n_checks++;
    if (valid_o !== 1'b1) begin
      n_err++;
      $display("FAIL %s: no valid_o within %0d cycles", nm, bound);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin : driver
    int t1, u0, v0, l0, ucnt0;
    bit prev_busy;
    logic [95:0] f;

    repeat (3) @(posedge clk);
    #1 chk_on = 1'b1;
    step();
    rst_n = 1'b1;

    // reset values
    @(negedge clk);
    chk("lit_reset_valid", {95'd0, valid_o}, 96'd0);
    chk("lit_reset_data", {dataz2, dataz, datay, datax}, 96'd0);
    chk("lit_reset_level", {91'd0, fifo_level}, 96'd0);
    chk("lit_reset_strm_ready", {95'd0, strm_ready}, 96'd1);
    chk("lit_reset_cfg_ready", {95'd0, cfg_ready}, 96'd1);

    // stream at interval 9: two frames ten cycles apart
    step();
    strm_valid = 1'b1; strm_data = {24'd4, 24'd3, 24'd2, 24'd1};
    step();
    strm_data = {24'd8, 24'd7, 24'd6, 24'd5};
    step();
    strm_valid = 1'b0; enable = 1'b1;
    l0 = n_late;
    wait_valid(100, "stream_first");
    chk("lit_stream_f1", {dataz2, dataz, datay, datax}, {24'd4, 24'd3, 24'd2, 24'd1});
    t1 = cyc;
    @(posedge clk);
    wait_valid(100, "stream_second");
    chk("lit_stream_gap", 96'(cyc - t1), 96'd10);
    chk("lit_stream_f2", {dataz2, dataz, datay, datax}, {24'd8, 24'd7, 24'd6, 24'd5});
    #1 chk("lit_stream_no_late", 96'(n_late - l0), 96'd0);
    step();
    enable = 1'b0; interval = 16'd4;
    repeat (10) step();

    // underrun with empty FIFO, interval 4
    enable = 1'b1;
    u0 = n_under; v0 = n_valid; ucnt0 = int'(underrun_cnt);
    repeat (51) @(negedge clk);
    #1;
    chk("lit_underrun_count", 96'(n_under - u0), 96'd10);
    chk("lit_underrun_no_valid", 96'(n_valid - v0), 96'd0);
    chk("lit_underrun_data_held", {dataz2, dataz, datay, datax}, {24'd8, 24'd7, 24'd6, 24'd5});
`ifdef GPA_FHDO_SCHED_STATS_EN
    chk("lit_underrun_cnt", 96'(int'(underrun_cnt) - ucnt0), 96'd10);
`else
    chk("lit_underrun_cnt", {80'd0, underrun_cnt}, 96'd0);
`endif
    step();
    enable = 1'b0; interval = 16'd0; busy_lo = 2; busy_hi = 5;
    repeat (10) step();

    // late: interval 0 with three frames, one issue per transfer
    strm_valid = 1'b1;
    repeat (3) begin
      strm_data = {$urandom, $urandom, $urandom};
      step();
    end
    strm_valid = 1'b0;
    step();
    enable = 1'b1;
    v0 = n_valid; l0 = n_late;
    repeat (80) @(negedge clk);
    #1;
    chk("lit_late_issues", 96'(n_valid - v0), 96'd3);
    chk("lit_late_seen", {95'd0, (n_late - l0) > 0}, 96'd1);
    step();
    enable = 1'b0; interval = 16'd9; busy_lo = 1; busy_hi = 3;
    repeat (10) step();

    // backpressure: 17 offers with the timer stopped, only 16 fit
    strm_valid = 1'b1;
    repeat (17) begin
      strm_data = {$urandom, $urandom, $urandom};
      step();
    end
    strm_valid = 1'b0;
    @(negedge clk);
    chk("lit_full_level", {91'd0, fifo_level}, 96'd16);
    chk("lit_full_ready", {95'd0, strm_ready}, 96'd0);
    step();
    enable = 1'b1;
    wait_valid(100, "drain_first");
    chk("lit_ready_after_read", {95'd0, strm_ready}, 96'd1);

    // reset during WAIT while the interface is still busy
    busy_lo = 25; busy_hi = 25;
    @(posedge clk);
    wait_valid(100, "pre_reset_issue");
    repeat (4) @(negedge clk);
    step();
    rst_n = 1'b0; enable = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    cfg_valid = 1'b1; cfg_data = {4{24'h0A0000}};
    @(negedge clk);
    chk("lit_rst_level", {91'd0, fifo_level}, 96'd0);
    chk("lit_rst_valid", {95'd0, valid_o}, 96'd0);
    chk("lit_rst_data", {dataz2, dataz, datay, datax}, 96'd0);
    chk("lit_rst_busy_still_high", {95'd0, busy_i}, 96'd1);
    prev_busy = busy_i;
    begin : wait_cfg
      for (int k = 0; k < 60; k++) begin
        @(negedge clk);
        if (valid_o === 1'b1) disable wait_cfg;
        prev_busy = busy_i;
      end
    end
    chk("lit_cfg_issued", {95'd0, valid_o}, 96'd1);
    chk("lit_cfg_after_busy", {95'd0, prev_busy}, 96'd0);
    chk("lit_cfg_data", {72'd0, datax}, 96'h0A0000);
    step();
    cfg_valid = 1'b0; busy_lo = 1; busy_hi = 3;
    repeat (30) step();

    // randomized traffic
    enable = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if (i % 250 == 0) begin
        interval = 16'($urandom_range(0, 12));
        busy_lo  = 1;
        busy_hi  = $urandom_range(1, 15);
      end
      if ($urandom_range(0, 199) == 0) enable = !enable;
      if ((i / 500) % 2 == 0) strm_valid = ($urandom_range(0, 1) == 0);
      else                    strm_valid = ($urandom_range(0, 19) == 0);
      f = {$urandom, $urandom, $urandom};
      strm_data = f;
      cfg_valid = ($urandom_range(0, 7) == 0);
      cfg_data  = {$urandom, $urandom, $urandom};
      rst_n     = ($urandom_range(0, 799) != 0);
      step();
    end
    rst_n = 1'b1; strm_valid = 1'b0; cfg_valid = 1'b0;
    repeat (5) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
